// File: rtl/pick_ctrl.sv
// Keyboard-to-motion controller: samples keycode once per frame tick and issues pick-cursor dir commands.
// Optional hold-to-accelerate (FAST states, hold counter) enabled by defining PICK_CTRL_ACCEL_EN.
module pick_ctrl #(
   parameter logic [7:0]  KEY_UP       = 8'h1A,
   parameter logic [7:0]  KEY_DOWN     = 8'h16,
   parameter int unsigned ACCEL_FRAMES = 16
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       pickMode,
   input  logic [7:0] keycode,
   output logic [2:0] dir,
   output logic       accel
);

   if (ACCEL_FRAMES < 1 || ACCEL_FRAMES > 255) begin : g_bad_accel
      $error("pick_ctrl: ACCEL_FRAMES must be in 1..255");
   end

   // frame_clk crosses into Clk through two flops; third flop detects the rising edge
   logic fs1_q, fs2_q, fs3_q;
   logic tick;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         fs1_q <= 1'b0;
         fs2_q <= 1'b0;
         fs3_q <= 1'b0;
      end else begin
         fs1_q <= frame_clk;
         fs2_q <= fs1_q;
         fs3_q <= fs2_q;
      end
   end

   assign tick = fs2_q & ~fs3_q;

   logic key_up, key_dn, key_none;
   assign key_up   = pickMode && (keycode == KEY_UP);
   assign key_dn   = pickMode && (keycode == KEY_DOWN) && (keycode != KEY_UP);
   assign key_none = !(key_up || key_dn);

`ifdef PICK_CTRL_ACCEL_EN
   localparam int unsigned CNT_W     = 8;
   localparam logic [CNT_W-1:0] ACCEL_MAX = CNT_W'(ACCEL_FRAMES);

   typedef enum logic [2:0] {IDLE, SLOW_UP, FAST_UP, SLOW_DN, FAST_DN} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign cnt_inc = (cnt_q >= ACCEL_MAX) ? cnt_q : cnt_q + CNT_W'(1);

   // Next state: a reversal or entry from IDLE always restarts slow with cnt=1
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (tick) begin
         if (key_none) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else if (key_up) begin
            case (state_q)
               SLOW_UP: begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == ACCEL_MAX) state_d = FAST_UP;
               end
               FAST_UP: cnt_d = cnt_inc;
               default: begin
                  state_d = SLOW_UP;
                  cnt_d   = CNT_W'(1);
               end
            endcase
         end else begin
            case (state_q)
               SLOW_DN: begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == ACCEL_MAX) state_d = FAST_DN;
               end
               FAST_DN: cnt_d = cnt_inc;
               default: begin
                  state_d = SLOW_DN;
                  cnt_d   = CNT_W'(1);
               end
            endcase
         end
      end
   end

   logic [2:0] dir_c;
   logic       accel_c;

   always_comb begin
      dir_c   = 3'd0;
      accel_c = 1'b0;
      case (state_q)
         SLOW_UP: dir_c = 3'd1;
         SLOW_DN: dir_c = 3'd2;
         FAST_DN: begin
            dir_c   = 3'd3;
            accel_c = 1'b1;
         end
         FAST_UP: begin
            dir_c   = 3'd4;
            accel_c = 1'b1;
         end
         default: dir_c = 3'd0;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         dir   <= 3'd0;
         accel <= 1'b0;
      end else begin
         dir   <= dir_c;
         accel <= accel_c;
      end
   end
`else
   typedef enum logic [1:0] {IDLE, SLOW_UP, SLOW_DN} state_t;

   state_t state_q, state_d;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (tick) begin
         if (key_none)    state_d = IDLE;
         else if (key_up) state_d = SLOW_UP;
         else             state_d = SLOW_DN;
      end
   end

   logic [2:0] dir_c;

   always_comb begin
      dir_c = 3'd0;
      case (state_q)
         SLOW_UP: dir_c = 3'd1;
         SLOW_DN: dir_c = 3'd2;
         default: dir_c = 3'd0;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) dir <= 3'd0;
      else       dir <= dir_c;
   end

   assign accel = 1'b0;
`endif

endmodule

// File: tb/tb_pick_ctrl.sv
// Self-checking bench for pick_ctrl: directed table, multi-cycle corner sequences and
// randomized frames checked against a run-length reference model. Honours PICK_CTRL_ACCEL_EN.
module tb_pick_ctrl;

   localparam logic [7:0] KUP = 8'h1A;
   localparam logic [7:0] KDN = 8'h16;
`ifdef PICK_CTRL_ACCEL_EN
   localparam bit ACC = 1'b1;
`else
   localparam bit ACC = 1'b0;
`endif
   localparam logic [2:0] D_UPF = ACC ? 3'd4 : 3'd1;
   localparam logic [2:0] D_DNF = ACC ? 3'd3 : 3'd2;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       frame_clk;
   logic       pickMode;
   logic [7:0] keycode;
   logic [2:0] dir0, dir1;
   logic       acc0, acc1;

   always #5 Clk = ~Clk;

   pick_ctrl #(.KEY_UP(KUP), .KEY_DOWN(KDN), .ACCEL_FRAMES(16)) u_dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .pickMode(pickMode),
      .keycode(keycode), .dir(dir0), .accel(acc0));

   pick_ctrl #(.KEY_UP(KUP), .KEY_DOWN(KDN), .ACCEL_FRAMES(1)) u_dut1 (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .pickMode(pickMode),
      .keycode(keycode), .dir(dir1), .accel(acc1));

   int nvec  = 0;
   int nfail = 0;

   task automatic check(input string name, input int got, input int exp);
      nvec++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference model: length of the current run of identical effective keys
   int run  = 0;
   int mkey = 0;   // 0 none, 1 up, 2 down

   function automatic int exp_dir(input int r, input int k, input int thr);
      bit fast;
      fast = ACC && (r >= thr) && (r >= 2);
      if (k == 1) return fast ? 4 : 1;
      if (k == 2) return fast ? 3 : 2;
      return 0;
   endfunction

   task automatic model_step(input logic [7:0] k, input logic pm);
      int eff;
      eff = !pm ? 0 : (k == KUP) ? 1 : (k == KDN) ? 2 : 0;
      if (eff == 0)         run = 0;
      else if (eff == mkey) run = run + 1;
      else                  run = 1;
      mkey = eff;
   endtask

   task automatic check_model(input string tag);
      int e16, e1;
      e16 = exp_dir(run, mkey, 16);
      e1  = exp_dir(run, mkey, 1);
      check({tag, "_dir16"}, int'(dir0), e16);
      check({tag, "_acc16"}, int'(acc0), (e16 >= 3) ? 1 : 0);
      check({tag, "_dir1"},  int'(dir1), e1);
      check({tag, "_acc1"},  int'(acc1), (e1 >= 3) ? 1 : 0);
   endtask

   // One frame: key presented at frame_clk rise, noise on keycode between ticks
   task automatic tick_frame(input logic [7:0] k, input logic pm, input int gap, input string tag);
      @(negedge Clk);
      keycode   = k;
      pickMode  = pm;
      frame_clk = 1'b1;
      repeat (4) @(posedge Clk);
      #1;
      model_step(k, pm);
      check_model(tag);
      @(negedge Clk);
      frame_clk = 1'b0;
      repeat (gap) begin
         @(negedge Clk);
         keycode = 8'($urandom);
      end
   endtask

   typedef struct {
      logic [7:0] k;
      logic       pm;
      int         reps;
      logic [2:0] dir;
      logic       acc;
   } vec_t;

   vec_t tbl[11];

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      logic [7:0] rk;
      logic       rpm;

      tbl[0]  = '{KUP,   1'b1, 15, 3'd1,  1'b0};
      tbl[1]  = '{KUP,   1'b1, 3,  D_UPF, ACC};
      tbl[2]  = '{KDN,   1'b1, 1,  3'd2,  1'b0};
      tbl[3]  = '{KDN,   1'b1, 14, 3'd2,  1'b0};
      tbl[4]  = '{KDN,   1'b1, 5,  D_DNF, ACC};
      tbl[5]  = '{KUP,   1'b1, 1,  3'd1,  1'b0};
      tbl[6]  = '{KUP,   1'b1, 3,  3'd1,  1'b0};
      tbl[7]  = '{KUP,   1'b0, 1,  3'd0,  1'b0};
      tbl[8]  = '{KUP,   1'b1, 1,  3'd1,  1'b0};
      tbl[9]  = '{8'h04, 1'b1, 1,  3'd0,  1'b0};
      tbl[10] = '{8'h00, 1'b1, 1,  3'd0,  1'b0};

      // Reset while frame_clk toggles with KEY_UP present; release with frame_clk high
      Reset     = 1'b1;
      frame_clk = 1'b0;
      keycode   = KUP;
      pickMode  = 1'b1;
      for (int i = 0; i < 7; i++) begin
         repeat (3) @(negedge Clk);
         frame_clk = ~frame_clk;
         check("rst_dir", int'(dir0), 0);
         check("rst_acc", int'(acc0), 0);
      end
      @(negedge Clk);
      Reset = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      check("rel_pre_dir", int'(dir0), 0);
      @(posedge Clk);
      #1;
      check("rel_first_tick_dir", int'(dir0), 1);
      model_step(KUP, 1'b1);
      check_model("rel");
      @(negedge Clk);
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
      tick_frame(8'h00, 1'b1, 3, "idle");

      // Directed table
      for (int v = 0; v < 11; v++) begin
         for (int r = 0; r < tbl[v].reps; r++) begin
            tick_frame(tbl[v].k, tbl[v].pm, 3 + (r % 3), "tblm");
            check($sformatf("tbl%0d_dir", v), int'(dir0), int'(tbl[v].dir));
            check($sformatf("tbl%0d_acc", v), int'(acc0), int'(tbl[v].acc));
         end
      end

      // KEY_DOWN pulse entirely between ticks is ignored
      @(negedge Clk);
      keycode = KDN;
      repeat (10) @(negedge Clk);
      keycode = 8'h00;
      repeat (3) @(negedge Clk);
      check("pulse_dir", int'(dir0), 0);
      tick_frame(8'h00, 1'b1, 3, "pulse");
      check("pulse_tick_dir", int'(dir0), 0);

      // frame_clk rise to dir change latency, bounded search
      @(negedge Clk);
      keycode   = KUP;
      pickMode  = 1'b1;
      frame_clk = 1'b1;
      lat = 0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge Clk);
         #1;
         if (dir0 != 3'd0) begin
            lat = i;
            break;
         end
      end
      check("latency_edges", lat, 4);
      model_step(KUP, 1'b1);
      check_model("lat");
      @(negedge Clk);
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);

      // Mid-frame asynchronous reset after reaching the fast state
      for (int i = 0; i < 17; i++) tick_frame(KUP, 1'b1, 3, "pre_rst");
      @(posedge Clk);
      #2;
      Reset = 1'b1;
      #1;
      check("async_rst_dir", int'(dir0), 0);
      check("async_rst_acc", int'(acc0), 0);
      check("async_rst_dir1", int'(dir1), 0);
      @(negedge Clk);
      Reset = 1'b0;
      run  = 0;
      mkey = 0;
      tick_frame(KUP, 1'b1, 3, "post_rst");
      check("post_rst_dir", int'(dir0), 1);

      // Long hold: saturation without wrap
      for (int i = 0; i < 300; i++) tick_frame(KUP, 1'b1, 3, "hold300");
      check("hold300_dir", int'(dir0), int'(D_UPF));
      check("hold300_acc", int'(acc0), int'(ACC));

      // Randomized frames against the model
      rk = KUP;
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 9) >= 7) begin
            case ($urandom_range(0, 4))
               0:       rk = KUP;
               1:       rk = KDN;
               2:       rk = 8'h04;
               3:       rk = 8'h00;
               default: rk = 8'($urandom);
            endcase
         end
         rpm = ($urandom_range(0, 9) != 0);
         tick_frame(rk, rpm, int'($urandom_range(3, 8)), "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
